instrumented_adder_sequencer: RTL and testbench
===============================================

INSTRUMENTED_ADDER_SEQUENCER -- requirements
Module: instrumented_adder_sequencer

Interface
REQ-001 Parameter WINDOW_W, default 16: width of the measurement-window count.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset; synchronous and active-high.
REQ-004 active  input  1  design-select enable; low forces abort and idle outputs.
REQ-005 start  input  1  single-cycle request to begin one measurement.
REQ-006 a_in  input  32  operand A, latched on accepted start.
REQ-007 b_in  input  32  operand B, latched on accepted start.
REQ-008 window  input  WINDOW_W  RUN duration in clocks, latched on accepted start.
REQ-009 ring_count  input  32  ring-oscillator edge count returned by the instrumented adder.
REQ-010 a_input  output  32  operand A driven to the adder.
REQ-011 b_input  output  32  operand B driven to the adder.
REQ-012 count_clear  output  1  clears the adder's ring counter.
REQ-013 run_ring  output  1  enables the ring oscillator through the adder chain.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when result is valid.
REQ-016 result  output  32  captured ring_count of the last completed measurement.
REQ-017 overflow  output  1  ring_count saturated during the last completed measurement.

Function
REQ-018 States SHALL be IDLE, LOAD, RUN, SETTLE and CAPTURE, held in a registered state variable.
REQ-019 IDLE -> LOAD SHALL occur when start=1, active=1 and window!=0; a_in, b_in and window are latched on that edge, and overflow is cleared.
REQ-020 A start with window=0 SHALL be ignored: the state stays IDLE and no done pulse is produced.
REQ-021 A start while busy=1 SHALL be ignored, with no change to the latched operands.
REQ-022 LOAD SHALL last 1 cycle with count_clear=1, run_ring=0 and a_input/b_input driving the latched operands.
REQ-023 RUN SHALL last exactly window cycles with run_ring=1, timed by a WINDOW_W-bit down-counter loaded with window.
REQ-024 SETTLE SHALL last exactly 2 cycles with run_ring=0, giving the count time to settle.
REQ-025 CAPTURE SHALL last 1 cycle: result <= ring_count, overflow <= (ring_count==32'hFFFFFFFF), and done=1 for exactly that cycle; the next state is IDLE.
REQ-026 Latency: start accepted at edge N SHALL give done=1 in the cycle after edge N+window+4; busy SHALL be high from edge N+1 to edge N+window+4.
REQ-027 window=2^WINDOW_W-1 SHALL run the full count with no counter wrap.
REQ-028 active falling in any non-IDLE state SHALL force IDLE on the next edge, with run_ring=0 and no done pulse; result and overflow keep their previous values.
REQ-029 a_input and b_input SHALL hold the latched operands until the next accepted start, including after an abort.
REQ-030 count_clear and run_ring SHALL never be high in the same cycle.
REQ-031 result and overflow SHALL change only in CAPTURE, on reset, or (overflow only) on an accepted start.

Reset
REQ-032 wb_rst_i=1 SHALL, on the next edge, set state=IDLE and clear a_input, b_input, result, overflow, done, busy, run_ring and count_clear to 0.
REQ-033 Reset SHALL take priority over start and over any in-progress state, including mid-RUN.
REQ-034 start asserted in the same cycle as wb_rst_i SHALL be ignored.

Verification
REQ-035 Nominal: a_in=0x0000FFFF, b_in=1, window=8, start at edge 0, ring_count held at 0x1234 -> run_ring high for 8 cycles, done at edge 12, result=0x1234, overflow=0.
REQ-036 Saturation: window=1, ring_count=0xFFFFFFFF -> done at edge 5, result=0xFFFFFFFF, overflow=1; a following start clears overflow to 0 at edge 1.
REQ-037 Ignored starts: start with window=0 -> busy stays 0, no done; a second start during RUN -> a_input unchanged and exactly one done pulse.
REQ-038 Abort: active dropped at the 3rd RUN cycle -> IDLE next edge, run_ring=0, no done, result keeps its prior value.
REQ-039 Reset mid-RUN: wb_rst_i pulsed with window=100 -> all outputs 0 on the next edge; a new start then completes normally.
REQ-040 Invariants, asserted throughout all scenarios: done high for at most 1 cycle per start; count_clear and run_ring never both high; busy=0 exactly when state=IDLE.

Source files
------------

// File: rtl/instrumented_adder_sequencer.sv
// Measurement sequencer for a ring-oscillator instrumented adder: drives the operands,
// clears and runs the ring counter for a programmable window, then captures the count.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for an accepted start, outputs quiescent
// LOAD    | operands driven, ring counter cleared
// RUN     | ring oscillator enabled for window cycles
// SETTLE  | ring stopped, two cycles for the count to settle
// CAPTURE | result valid, done pulse
module instrumented_adder_sequencer #(
    parameter int WINDOW_W = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                active,
    input  logic                start,
    input  logic [31:0]         a_in,
    input  logic [31:0]         b_in,
    input  logic [WINDOW_W-1:0] window,
    input  logic [31:0]         ring_count,
    output logic [31:0]         a_input,
    output logic [31:0]         b_input,
    output logic                count_clear,
    output logic                run_ring,
    output logic                busy,
    output logic                done,
    output logic [31:0]         result,
    output logic                overflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4
    } state_t;

    state_t              r_state;
    logic [WINDOW_W-1:0] r_cnt;
    logic                r_settle;
    logic [31:0]         r_a_input;
    logic [31:0]         r_b_input;
    logic                r_count_clear;
    logic                r_run_ring;
    logic                r_busy;
    logic                r_done;
    logic [31:0]         r_result;
    logic                r_overflow;

    logic w_accept;
    logic w_abort;
    logic w_run_last;

    assign w_accept   = start && active && (window != '0);
    assign w_abort    = !active && (r_state != IDLE);
    assign w_run_last = (r_cnt == WINDOW_W'(1));

    // Outputs are registered alongside the next state so they line up with it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_settle      <= 1'b0;
            r_a_input     <= '0;
            r_b_input     <= '0;
            r_count_clear <= 1'b0;
            r_run_ring    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_overflow    <= 1'b0;
        end else if (w_abort) begin
            r_state       <= IDLE;
            r_count_clear <= 1'b0;
            r_run_ring    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_count_clear <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= LOAD;
                        r_a_input     <= a_in;
                        r_b_input     <= b_in;
                        r_cnt         <= window;
                        r_overflow    <= 1'b0;
                        r_busy        <= 1'b1;
                        r_count_clear <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state    <= RUN;
                    r_run_ring <= 1'b1;
                end
                RUN: begin
                    // Terminal count of 1 gives exactly window RUN cycles, even at all-ones.
                    if (w_run_last) begin
                        r_state    <= SETTLE;
                        r_run_ring <= 1'b0;
                        r_settle   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - WINDOW_W'(1);
                    end
                end
                SETTLE: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else begin
                        r_state    <= CAPTURE;
                        r_done     <= 1'b1;
                        r_result   <= ring_count;
                        r_overflow <= (ring_count == 32'hFFFF_FFFF);
                    end
                end
                CAPTURE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_run_ring <= 1'b0;
                end
            endcase
        end
    end

    assign a_input     = r_a_input;
    assign b_input     = r_b_input;
    assign count_clear = r_count_clear;
    assign run_ring    = r_run_ring;
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Scoreboard bench for instrumented_adder_sequencer: directed measurements push expected
// results; a negedge monitor checks each done pulse, run length, latency and invariants.
module tb_instrumented_adder_sequencer;

    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          active;
    logic          start;
    logic [31:0]   a_in;
    logic [31:0]   b_in;
    logic [WW-1:0] window;
    logic [31:0]   ring_count;
    logic [31:0]   a_input;
    logic [31:0]   b_input;
    logic          count_clear;
    logic          run_ring;
    logic          busy;
    logic          done;
    logic [31:0]   result;
    logic          overflow;

    instrumented_adder_sequencer #(.WINDOW_W(WW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .active      (active),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .window      (window),
        .ring_count  (ring_count),
        .a_input     (a_input),
        .b_input     (b_input),
        .count_clear (count_clear),
        .run_ring    (run_ring),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          cyc;
        int          run;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   run_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic violation(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: invariant violated at cycle %0d", name, cyc);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (count_clear === 1'b1) run_cnt = 0;
        if (run_ring === 1'b1) run_cnt++;
        if (count_clear === 1'b1 && run_ring === 1'b1) violation("clear_and_run");
        if (busy !== (dut.r_state != 3'd0)) violation("busy_vs_state");
        if (prev_done === 1'b1 && done === 1'b1) violation("done_two_cycles");
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("a_input", a_input, e.a);
                chk("b_input", b_input, e.b);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("run_cycles", 32'(run_cnt), 32'(e.run));
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int w,
                         input logic [31:0] ring, input bit push);
        exp_t e;
        @(posedge clk); #1;
        a_in = a;
        b_in = b;
        window = WW'(w);
        ring_count = ring;
        start = 1'b1;
        if (push) begin
            e.a   = a;
            e.b   = b;
            e.res = ring;
            e.ovf = (ring == 32'hFFFF_FFFF);
            e.cyc = cyc + w + 4;
            e.run = w;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (q.size() == 0 && busy === 1'b0) break;
            @(posedge clk);
        end
        @(negedge clk);
        chk("drain_timeout", 32'(q.size()), 32'd0);
        chk("idle_after_drain", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_input"}, a_input, 32'd0);
        chk({tag, "_b_input"}, b_input, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_flags"}, {26'd0, overflow, done, busy, run_ring, count_clear, 1'b0}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        active = 1'b1;
        start = 1'b1;
        a_in = 32'hDEAD_BEEF;
        b_in = 32'hCAFE_F00D;
        window = WW'(5);
        ring_count = 32'd0;

        // Reset with a simultaneous start: start must be ignored.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // Nominal measurement.
        issue(32'h0000_FFFF, 32'd1, 8, 32'h0000_1234, 1'b1);
        drain(50);

        // Saturated count, then a start that must clear overflow on acceptance.
        issue(32'd3, 32'd4, 1, 32'hFFFF_FFFF, 1'b1);
        drain(50);
        chk("sat_overflow_held", {31'd0, overflow}, 32'd1);
        issue(32'd5, 32'd6, 2, 32'h0000_0055, 1'b1);
        @(negedge clk);
        chk("overflow_cleared_on_start", {31'd0, overflow}, 32'd0);
        drain(50);

        // window=0 start is ignored entirely.
        issue(32'd7, 32'd8, 0, 32'h0000_0055, 1'b0);
        repeat (3) @(negedge clk);
        chk("win0_busy", {31'd0, busy}, 32'd0);
        chk("win0_a_input", a_input, 32'd5);

        // A second start while busy is ignored.
        issue(32'h11, 32'h22, 6, 32'h0000_600D, 1'b1);
        repeat (2) @(posedge clk);
        issue(32'h99, 32'h98, 6, 32'h0000_600D, 1'b0);
        @(negedge clk);
        chk("busy_start_a_input", a_input, 32'h11);
        drain(50);

        // Abort on the third RUN cycle.
        issue(32'h33, 32'h44, 10, 32'h0000_0777, 1'b0);
        repeat (3) @(posedge clk);
        #1 active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_run_ring", {31'd0, run_ring}, 32'd0);
        chk("abort_result", result, 32'h0000_600D);
        chk("abort_a_input", a_input, 32'h33);
        #1 active = 1'b1;
        repeat (15) @(negedge clk);

        // Reset mid-RUN, then a normal measurement.
        issue(32'hA5A5, 32'h5A5A, 100, 32'd1, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        issue(32'd1, 32'd2, 3, 32'h0000_BEEF, 1'b1);
        drain(50);

        // Full-scale window: no counter wrap.
        issue(32'hFFFF_FFFF, 32'd1, 255, 32'h0000_1000, 1'b1);
        drain(400);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
